uart_tx_ctrl: RTL and testbench



---
 rtl/uart_tx_ctrl.sv | 169 ++++++++++++++++
 tb/tb_uart_tx_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl
//   UART transmit controller running in the TX baud clock domain. Each CLK
//   edge advances the serial line by one frame bit. The controller captures
//   a word, sends it LSB first with an optional even/odd parity bit and one
//   or two stop bits. It can take the next word during the final stop bit,
//   so back-to-back frames have no idle gap.
//
// Parameters
//   DATA_WIDTH  data bits per frame (5..16)
//
// Ports
//   CLK         TX baud clock, rising edge
//   RST         asynchronous reset, active low
//   P_DATA      parallel word, sampled only on acceptance
//   Data_Valid  word available (level sensitive)
//   PAR_EN      parity bit enable, sampled on acceptance
//   PAR_TYP     0 = even parity, 1 = odd parity, sampled on acceptance
//   STOP2       1 = two stop bits, sampled on acceptance
//   TX_OUT      registered serial line (idle high)
//   busy        registered, high for every cycle of a frame
//   Data_Ack    registered one-cycle pulse in the start-bit cycle
module uart_tx_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
  output logic                  TX_OUT,
  output logic                  busy,
  output logic                  Data_Ack
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        bit_cnt, bit_cnt_nxt;
  logic                    stop_cnt, stop_cnt_nxt;
  logic                    par_en_q, par_en_nxt;
  logic                    stop2_q, stop2_nxt;
  logic [DATA_WIDTH-1:0]   shreg, shreg_nxt;
  logic                    par_bit, par_bit_nxt;
  logic                    tx_nxt, busy_nxt, ack_nxt;
  logic                    accept;

  function automatic logic parity_of(input logic [DATA_WIDTH-1:0] data,
                                     input logic odd);
    return (^data) ^ odd;
  endfunction

  // Next-state and next-output decode. Outputs are computed for the state
  // being entered so that the registered outputs line up with that state.
  always_comb begin
    state_nxt    = state;
    bit_cnt_nxt  = bit_cnt;
    stop_cnt_nxt = stop_cnt;
    par_en_nxt   = par_en_q;
    stop2_nxt    = stop2_q;
    shreg_nxt    = shreg;
    par_bit_nxt  = par_bit;
    tx_nxt       = 1'b1;
    busy_nxt     = 1'b0;
    ack_nxt      = 1'b0;
    accept       = 1'b0;

    case (state)
      IDLE: begin
        accept = Data_Valid;
      end
      START: begin
        state_nxt   = DATA;
        bit_cnt_nxt = '0;
        tx_nxt      = shreg[0];
        shreg_nxt   = shreg >> 1;
        busy_nxt    = 1'b1;
      end
      DATA: begin
        busy_nxt = 1'b1;
        if (bit_cnt == LAST_BIT) begin
          stop_cnt_nxt = 1'b0;
          if (par_en_q) begin
            state_nxt = PARITY;
            tx_nxt    = par_bit;
          end else begin
            state_nxt = STOP;
          end
        end else begin
          // bit_cnt tracks the bit currently on the line; shreg[0] is the next one
          bit_cnt_nxt = bit_cnt + CNT_W'(1);
          tx_nxt      = shreg[0];
          shreg_nxt   = shreg >> 1;
        end
      end
      PARITY: begin
        state_nxt    = STOP;
        stop_cnt_nxt = 1'b0;
        busy_nxt     = 1'b1;
      end
      STOP: begin
        if (stop_cnt != stop2_q) begin
          stop_cnt_nxt = 1'b1;
          busy_nxt     = 1'b1;
        end else if (Data_Valid) begin
          accept = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    if (accept) begin
      state_nxt    = START;
      bit_cnt_nxt  = '0;
      stop_cnt_nxt = 1'b0;
      par_en_nxt   = PAR_EN;
      stop2_nxt    = STOP2;
      shreg_nxt    = P_DATA;
      par_bit_nxt  = parity_of(P_DATA, PAR_TYP);
      tx_nxt       = 1'b0;
      busy_nxt     = 1'b1;
      ack_nxt      = 1'b1;
    end
  end

  // Control and output registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      par_en_q <= 1'b0;
      stop2_q  <= 1'b0;
      TX_OUT   <= 1'b1;
      busy     <= 1'b0;
      Data_Ack <= 1'b0;
    end else begin
      state    <= state_nxt;
      bit_cnt  <= bit_cnt_nxt;
      stop_cnt <= stop_cnt_nxt;
      par_en_q <= par_en_nxt;
      stop2_q  <= stop2_nxt;
      TX_OUT   <= tx_nxt;
      busy     <= busy_nxt;
      Data_Ack <= ack_nxt;
    end
  end

  // Frame data registers
  always_ff @(posedge CLK) begin
    shreg   <= shreg_nxt;
    par_bit <= par_bit_nxt;
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
module tb_uart_tx_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [7:0] d8;
  logic       dv8, pe8, pt8, s28, tx8, busy8, ack8;
  logic [4:0] d5;
  logic       dv5, pe5, pt5, s25, tx5, busy5, ack5;

  uart_tx_ctrl #(.DATA_WIDTH(8)) dut8 (
    .CLK(clk), .RST(rst_n), .P_DATA(d8), .Data_Valid(dv8),
    .PAR_EN(pe8), .PAR_TYP(pt8), .STOP2(s28),
    .TX_OUT(tx8), .busy(busy8), .Data_Ack(ack8)
  );

  uart_tx_ctrl #(.DATA_WIDTH(5)) dut5 (
    .CLK(clk), .RST(rst_n), .P_DATA(d5), .Data_Valid(dv5),
    .PAR_EN(pe5), .PAR_TYP(pt5), .STOP2(s25),
    .TX_OUT(tx5), .busy(busy5), .Data_Ack(ack5)
  );

  typedef struct {
    int   sel;
    int   cyc;
    logic tx;
    logic busy;
    logic ack;
  } exp_t;

  exp_t sbq[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compares every expected entry due in the current cycle
  exp_t       mon_e;
  logic [2:0] mon_act, mon_req;
  always @(negedge clk) begin
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      mon_e   = sbq.pop_front();
      mon_act = (mon_e.sel == 1) ? {tx5, busy5, ack5} : {tx8, busy8, ack8};
      mon_req = {mon_e.tx, mon_e.busy, mon_e.ack};
      checks++;
      if (mon_e.cyc < cyc) begin
        errors++;
        $display("FAIL stale_entry dut%0d cyc %0d seen at cyc %0d", mon_e.sel, mon_e.cyc, cyc);
      end else if (mon_act !== mon_req) begin
        errors++;
        $display("FAIL frame dut%0d cyc %0d tx/busy/ack got %b required %b",
                 mon_e.sel, mon_e.cyc, mon_act, mon_req);
      end
    end
  end

  task automatic push(input int sel, input int c, input logic tx, input logic b, input logic a);
    sbq.push_back('{sel, c, tx, b, a});
  endtask

  task automatic push_frame(input int sel, input int c0, input logic [15:0] d, input int dw,
                            input bit pe, input bit par, input bit s2, output int nxt);
    int k;
    push(sel, c0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < dw; i++) push(sel, c0 + 1 + i, d[i], 1'b1, 1'b0);
    k = c0 + 1 + dw;
    if (pe) begin
      push(sel, k, par, 1'b1, 1'b0);
      k++;
    end
    push(sel, k, 1'b1, 1'b1, 1'b0);
    k++;
    if (s2) begin
      push(sel, k, 1'b1, 1'b1, 1'b0);
      k++;
    end
    nxt = k;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One frame; par is the hand-computed parity bit
  task automatic send(input int sel, input logic [15:0] d, input bit pe, input bit pt,
                      input bit s2, input bit par, input bit mid);
    int c, e;
    @(posedge clk);
    #1;
    c = cyc;
    push(sel, c, 1'b1, 1'b0, 1'b0);
    if (sel == 1) begin
      d5 = d[4:0]; pe5 = pe; pt5 = pt; s25 = s2; dv5 = 1'b1;
    end else begin
      d8 = d[7:0]; pe8 = pe; pt8 = pt; s28 = s2; dv8 = 1'b1;
    end
    push_frame(sel, c + 1, d, (sel == 1) ? 5 : 8, pe, par, s2, e);
    push(sel, e, 1'b1, 1'b0, 1'b0);
    push(sel, e + 1, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    dv8 = 1'b0;
    dv5 = 1'b0;
    if (mid) begin
      wait_until(c + 4);
      s28 = ~s28; d8 = ~d8; pe8 = ~pe8; pt8 = ~pt8;
      wait_until(c + 7);
      d8 = 8'h5A;
    end
    wait_until(e + 2);
  endtask

  task automatic back_to_back();
    int c, e1, e2;
    @(posedge clk);
    #1;
    c = cyc;
    push(0, c, 1'b1, 1'b0, 1'b0);
    d8 = 8'h3C; pe8 = 1'b0; pt8 = 1'b0; s28 = 1'b0; dv8 = 1'b1;
    push_frame(0, c + 1, 16'h003C, 8, 1'b0, 1'b0, 1'b0, e1);
    push_frame(0, e1, 16'h00C3, 8, 1'b0, 1'b0, 1'b0, e2);
    push(0, e2, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    d8 = 8'hC3;
    wait_until(e1);
    dv8 = 1'b0;
    wait_until(e2 + 1);
  endtask

  task automatic reset_mid_frame();
    int c, e;
    logic [7:0] a5;
    a5 = 8'hA5;
    @(posedge clk);
    #1;
    c = cyc;
    push(0, c, 1'b1, 1'b0, 1'b0);
    d8 = 8'hA5; pe8 = 1'b0; pt8 = 1'b0; s28 = 1'b0; dv8 = 1'b1;
    push(0, c + 1, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) push(0, c + 2 + i, a5[i], 1'b1, 1'b0);
    // bit 4 would be on the line in cycle c+6; reset lands before it is sampled
    push(0, c + 6, 1'b1, 1'b0, 1'b0);
    push(0, c + 7, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    dv8 = 1'b0;
    wait_until(c + 6);
    #1;
    rst_n = 1'b0;
    d8 = 8'h5A; dv8 = 1'b1;
    wait_until(c + 7);
    rst_n = 1'b1;
    push_frame(0, c + 8, 16'h005A, 8, 1'b0, 1'b0, 1'b0, e);
    push(0, e, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    dv8 = 1'b0;
    wait_until(e + 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    d8 = '0; dv8 = 1'b0; pe8 = 1'b0; pt8 = 1'b0; s28 = 1'b0;
    d5 = '0; dv5 = 1'b0; pe5 = 1'b0; pt5 = 1'b0; s25 = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      push(0, c, 1'b1, 1'b0, 1'b0);
      push(1, c, 1'b1, 1'b0, 1'b0);
    end
    wait_until(2);
    rst_n = 1'b1;

    // 0xA5 plain, then parity variants (popcount 4 -> even 0, odd 1; 0x01 even -> 1)
    send(0, 16'h00A5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send(0, 16'h00A5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send(0, 16'h00A5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    send(0, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    // two stop bits with mid-frame input changes
    send(0, 16'h00FF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    back_to_back();
    reset_mid_frame();
    // 5-bit word 0x15, popcount 3 -> even parity 1
    send(1, 16'h0015, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 50 && sbq.size() > 0; i++) @(posedge clk);
    if (sbq.size() > 0) begin
      $display("FAIL drain %0d expected entries never checked, required 0", sbq.size());
      errors += sbq.size();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
